// File: rtl/lsq_inorder_param.sv
// rtl/lsq_inorder_param.sv - program-ordered load/store queue with CDB wakeup and head-only memory issue
// Circular FIFO of memory ops; one outstanding memory access at a time, always from the head.
module lsq_inorder_param #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic              issue_store,
  input  logic [TAG_W-1:0]  issue_rob_tag,
  input  logic              issue_addr_rdy,
  input  logic [TAG_W-1:0]  issue_addr_tag,
  input  logic [ADDR_W-1:0] issue_addr_val,
  input  logic              issue_data_rdy,
  input  logic [TAG_W-1:0]  issue_data_tag,
  input  logic [DATA_W-1:0] issue_data_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_read_val,
  output logic              lsu_done,
  output logic [TAG_W-1:0]  lsu_tag,
  output logic [DATA_W-1:0] lsu_val,
  output logic              lsq_full,
  output logic              lsq_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TAG_W-1:0] TAG_NONE = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DRAIN} state_t;

  state_t            state_q;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  vld_q, st_q, ardy_q, drdy_q;
  logic [TAG_W-1:0]  rtag_q [DEPTH];
  logic [TAG_W-1:0]  atag_q [DEPTH];
  logic [TAG_W-1:0]  dtag_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              alloc, pop, head_elig;
  logic              new_ardy, new_drdy;
  logic [ADDR_W-1:0] new_addr;
  logic [DATA_W-1:0] new_data;

  // The NONE tag marks "no producer" and must never be woken by a broadcast.
  function automatic logic cdb_match(input logic [TAG_W-1:0] t);
    return cdb_valid && (t == cdb_tag) && (t != TAG_NONE);
  endfunction

  assign lsq_full  = (count_q == CW'(DEPTH)) || (state_q == S_DRAIN);
  assign lsq_empty = (count_q == '0);

  assign alloc     = issue_en && !lsq_full && !flush;
  assign pop       = (state_q == S_WAIT_ACK) && mem_ack && !flush;
  assign head_elig = vld_q[head_q] && ardy_q[head_q] && (!st_q[head_q] || drdy_q[head_q]);

  assign new_ardy  = issue_addr_rdy || cdb_match(issue_addr_tag);
  assign new_addr  = issue_addr_rdy ? issue_addr_val : ADDR_W'(cdb_data);
  assign new_drdy  = issue_data_rdy || cdb_match(issue_data_tag);
  assign new_data  = issue_data_rdy ? issue_data_val : cdb_data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (alloc) tail_d = tail_q + PW'(1);
      if (pop)   head_d = head_q + PW'(1);
      count_d = count_q + CW'(alloc) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      st_q     <= '0;
      ardy_q   <= '0;
      drdy_q   <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      lsu_done <= 1'b0;
      lsu_tag  <= '0;
      lsu_val  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rtag_q[i] <= '0;
        atag_q[i] <= '0;
        dtag_q[i] <= '0;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      lsu_done <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && !ardy_q[i] && cdb_match(atag_q[i])) begin
          ardy_q[i] <= 1'b1;
          addr_q[i] <= ADDR_W'(cdb_data);
        end
        if (vld_q[i] && !drdy_q[i] && cdb_match(dtag_q[i])) begin
          drdy_q[i] <= 1'b1;
          data_q[i] <= cdb_data;
        end
      end

      // The tail slot is never valid when alloc is set, so this cannot collide with wakeup.
      if (alloc) begin
        vld_q[tail_q]  <= 1'b1;
        st_q[tail_q]   <= issue_store;
        rtag_q[tail_q] <= issue_rob_tag;
        ardy_q[tail_q] <= new_ardy;
        atag_q[tail_q] <= issue_addr_tag;
        addr_q[tail_q] <= new_addr;
        drdy_q[tail_q] <= new_drdy;
        dtag_q[tail_q] <= issue_data_tag;
        data_q[tail_q] <= new_data;
      end

      case (state_q)
        S_IDLE: begin
          if (!flush && head_elig) begin
            mem_req  <= 1'b1;
            mem_we   <= st_q[head_q];
            mem_addr <= addr_q[head_q];
            mem_data <= st_q[head_q] ? data_q[head_q] : '0;
            state_q  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= S_IDLE;
            if (!flush) begin
              lsu_done      <= 1'b1;
              lsu_tag       <= rtag_q[head_q];
              lsu_val       <= st_q[head_q] ? '0 : mem_read_val;
              vld_q[head_q] <= 1'b0;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The flushed request is still owned by memory; retire it silently.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (flush) vld_q <= '0;
    end
  end

endmodule

// File: tb/tb_lsq_inorder_param.sv
// tb/tb_lsq_inorder_param.sv - vector table, directed corner cases and random run against a queue model
module tb_lsq_inorder_param;
  localparam int DEPTH = 8, TAG_W = 5, DATA_W = 32, ADDR_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, issue_en, issue_store, issue_addr_rdy, issue_data_rdy, cdb_valid, flush, mem_ack;
  logic [TAG_W-1:0] issue_rob_tag, issue_addr_tag, issue_data_tag, cdb_tag, lsu_tag;
  logic [ADDR_W-1:0] issue_addr_val, mem_addr;
  logic [DATA_W-1:0] issue_data_val, cdb_data, mem_data, mem_read_val, lsu_val;
  logic mem_req, mem_we, lsu_done, lsq_full, lsq_empty;

  lsq_inorder_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .issue_store(issue_store),
    .issue_rob_tag(issue_rob_tag), .issue_addr_rdy(issue_addr_rdy), .issue_addr_tag(issue_addr_tag),
    .issue_addr_val(issue_addr_val), .issue_data_rdy(issue_data_rdy), .issue_data_tag(issue_data_tag),
    .issue_data_val(issue_data_val), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ack(mem_ack), .mem_read_val(mem_read_val), .lsu_done(lsu_done), .lsu_tag(lsu_tag),
    .lsu_val(lsu_val), .lsq_full(lsq_full), .lsq_empty(lsq_empty)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    issue_en = 0; issue_store = 0; issue_rob_tag = 0; issue_addr_rdy = 0; issue_addr_tag = 0;
    issue_addr_val = 0; issue_data_rdy = 0; issue_data_tag = 0; issue_data_val = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; flush = 0; mem_ack = 0; mem_read_val = 0;
  endtask

  task automatic iss(input logic st, input logic [4:0] rt, input logic ar, input logic [4:0] at,
                     input logic [31:0] av, input logic dr, input logic [4:0] dt, input logic [31:0] dv);
    issue_en = 1; issue_store = st; issue_rob_tag = rt; issue_addr_rdy = ar; issue_addr_tag = at;
    issue_addr_val = av; issue_data_rdy = dr; issue_data_tag = dt; issue_data_val = dv;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    chk(nm, mem_req, 1);
  endtask

  typedef struct {
    logic ie, st; logic [4:0] rt; logic ar; logic [4:0] at; logic [31:0] av;
    logic dr; logic [4:0] dt; logic [31:0] dv;
    logic cv; logic [4:0] ct; logic [31:0] cd; logic fl, ack; logic [31:0] rd;
    logic req, we; logic [31:0] addr, data; logic done; logic [4:0] tag; logic [31:0] val;
    logic full, empty;
  } vec_t;

  function automatic vec_t ex(logic req, logic we, logic [31:0] addr, logic [31:0] data, logic done,
                              logic [4:0] tag, logic [31:0] val, logic full, logic empty);
    vec_t v = '{default: '0};
    v.req = req; v.we = we; v.addr = addr; v.data = data; v.done = done;
    v.tag = tag; v.val = val; v.full = full; v.empty = empty;
    return v;
  endfunction

  function automatic vec_t w_ld(vec_t v, logic [4:0] rt, logic ar, logic [4:0] at, logic [31:0] av);
    v.ie = 1; v.st = 0; v.rt = rt; v.ar = ar; v.at = at; v.av = av; v.dr = 0; v.dt = 5'd30;
    return v;
  endfunction

  function automatic vec_t w_st(vec_t v, logic [4:0] rt, logic ar, logic [4:0] at, logic [31:0] av,
                                logic dr, logic [4:0] dt, logic [31:0] dv);
    v.ie = 1; v.st = 1; v.rt = rt; v.ar = ar; v.at = at; v.av = av; v.dr = dr; v.dt = dt; v.dv = dv;
    return v;
  endfunction

  function automatic vec_t w_cdb(vec_t v, logic [4:0] ct, logic [31:0] cd);
    v.cv = 1; v.ct = ct; v.cd = cd;
    return v;
  endfunction

  function automatic vec_t w_ack(vec_t v, logic [31:0] rd);
    v.ack = 1; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t w_fl(vec_t v);
    v.fl = 1;
    return v;
  endfunction

  typedef struct {
    logic st; logic [4:0] rt; logic ar; logic [4:0] at; logic [31:0] av;
    logic dr; logic [4:0] dt; logic [31:0] dv;
  } ment_t;

  function automatic logic hit(logic cv, logic [4:0] ct, logic [4:0] t);
    return cv && (t == ct) && (t != 5'h1f);
  endfunction

  function automatic logic [4:0] rnd_tag();
    return ($urandom % 12 == 0) ? 5'h1f : 5'($urandom % 8);
  endfunction

  vec_t tbl[$];
  ment_t mq[$];

  initial begin
    vec_t v;
    ment_t ne;
    int mmode;
    logic mreq, mwe, mdone, elig, mfull, alloc;
    logic [31:0] maddr, mdata, mval;
    logic [4:0] mtag;

    // test 1: ready load, ack two cycles after the request
    tbl.push_back(w_ld(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd3, 1, 5'd0, 32'h40));
    tbl.push_back(ex(1, 0, 32'h40, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(1, 0, 32'h40, 0, 0, 0, 0, 0, 0));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 1, 5'd3, 32'hDEADBEEF, 0, 1), 32'hDEADBEEF));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // test 2: store with both operands woken from the CDB
    tbl.push_back(w_st(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd4, 0, 5'd7, 0, 0, 5'd9, 0));
    tbl.push_back(w_cdb(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd7, 32'h100));
    tbl.push_back(w_cdb(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd9, 32'h55));
    tbl.push_back(ex(1, 1, 32'h100, 32'h55, 0, 0, 0, 0, 0));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 1, 5'd4, 0, 0, 1), 32'hCAFE));
    // test 5: same-cycle CDB bypass at issue
    tbl.push_back(w_cdb(w_ld(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd6, 0, 5'd10, 0), 5'd10, 32'h200));
    tbl.push_back(ex(1, 0, 32'h200, 0, 0, 0, 0, 0, 0));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 1, 5'd6, 32'h1234, 0, 1), 32'h1234));
    // test 6: flush while the request is held, drain, then accept again
    tbl.push_back(w_ld(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd1, 1, 5'd0, 32'h300));
    tbl.push_back(w_ld(ex(1, 0, 32'h300, 0, 0, 0, 0, 0, 0), 5'd2, 1, 5'd0, 32'h304));
    tbl.push_back(w_fl(ex(1, 0, 32'h300, 0, 0, 0, 0, 1, 1)));
    tbl.push_back(w_ld(ex(1, 0, 32'h300, 0, 0, 0, 0, 1, 1), 5'd8, 1, 5'd0, 32'h400));
    tbl.push_back(ex(1, 0, 32'h300, 0, 0, 0, 0, 1, 1));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 0, 0, 0, 0, 1), 32'h99));
    tbl.push_back(w_ld(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd8, 1, 5'd0, 32'h400));
    tbl.push_back(ex(1, 0, 32'h400, 0, 0, 0, 0, 0, 0));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 1, 5'd8, 32'h77, 0, 1), 32'h77));
    // flush coincident with ack, then a stray ack with no request
    tbl.push_back(w_ld(ex(0, 0, 0, 0, 0, 0, 0, 0, 0), 5'd11, 1, 5'd0, 32'h500));
    tbl.push_back(ex(1, 0, 32'h500, 0, 0, 0, 0, 0, 0));
    tbl.push_back(w_fl(w_ack(ex(0, 0, 0, 0, 0, 0, 0, 0, 1), 32'h88)));
    tbl.push_back(w_ack(ex(0, 0, 0, 0, 0, 0, 0, 0, 1), 32'h66));

    idle_in();
    rst_n = 0;
    step();
    step();
    chk("rst.req", mem_req, 0);      chk("rst.we", mem_we, 0);
    chk("rst.addr", mem_addr, 0);    chk("rst.data", mem_data, 0);
    chk("rst.done", lsu_done, 0);    chk("rst.tag", 32'(lsu_tag), 0);
    chk("rst.val", lsu_val, 0);      chk("rst.full", lsq_full, 0);
    chk("rst.empty", lsq_empty, 1);
    rst_n = 1;
    step();

    foreach (tbl[i]) begin
      v = tbl[i];
      issue_en = v.ie; issue_store = v.st; issue_rob_tag = v.rt; issue_addr_rdy = v.ar;
      issue_addr_tag = v.at; issue_addr_val = v.av; issue_data_rdy = v.dr; issue_data_tag = v.dt;
      issue_data_val = v.dv; cdb_valid = v.cv; cdb_tag = v.ct; cdb_data = v.cd;
      flush = v.fl; mem_ack = v.ack; mem_read_val = v.rd;
      step();
      chk($sformatf("v%0d.req", i), mem_req, v.req);
      if (v.req) begin
        chk($sformatf("v%0d.we", i), mem_we, v.we);
        chk($sformatf("v%0d.addr", i), mem_addr, v.addr);
        chk($sformatf("v%0d.data", i), mem_data, v.data);
      end
      chk($sformatf("v%0d.done", i), lsu_done, v.done);
      if (v.done) begin
        chk($sformatf("v%0d.tag", i), 32'(lsu_tag), 32'(v.tag));
        chk($sformatf("v%0d.val", i), lsu_val, v.val);
      end
      chk($sformatf("v%0d.full", i), lsq_full, v.full);
      chk($sformatf("v%0d.empty", i), lsq_empty, v.empty);
    end
    idle_in();

    // test 3: fill, overflow drop, in-order drain, then wrap
    for (int k = 0; k < 8; k++) begin
      iss(0, 5'(k), 1, 0, 32'(k * 4), 0, 0, 0);
      step();
    end
    idle_in();
    chk("t3.full8", lsq_full, 1);
    iss(0, 5'd20, 1, 0, 32'hF00, 0, 0, 0);
    step();
    idle_in();
    chk("t3.full9", lsq_full, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        chk("t3.empty", lsq_empty, 1);
        iss(0, 5'd21, 1, 0, 32'h700, 0, 0, 0); step();
        iss(0, 5'd22, 1, 0, 32'h704, 0, 0, 0); step();
        idle_in();
      end
      wait_req($sformatf("t3.req%0d", k));
      chk($sformatf("t3.addr%0d", k), mem_addr, (k < 8) ? 32'(k * 4) : 32'h700 + 32'((k - 8) * 4));
      mem_ack = 1; mem_read_val = 32'(k + 100);
      step();
      idle_in();
      chk($sformatf("t3.done%0d", k), lsu_done, 1);
      chk($sformatf("t3.tag%0d", k), 32'(lsu_tag), (k < 8) ? 32'(k) : 32'(k + 13));
    end
    chk("t3.empty2", lsq_empty, 1);

    // test 4: blocked head holds back a ready younger load
    iss(0, 5'd1, 0, 5'd12, 0, 0, 0, 0); step();
    iss(0, 5'd2, 1, 0, 32'h600, 0, 0, 0); step();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t4.noreq%0d", k), mem_req, 0);
    end
    cdb_valid = 1; cdb_tag = 5'd12; cdb_data = 32'h700;
    step();
    idle_in();
    wait_req("t4.req0");
    chk("t4.addr0", mem_addr, 32'h700);
    mem_ack = 1; mem_read_val = 32'hA; step(); idle_in();
    chk("t4.tag0", 32'(lsu_tag), 1);
    chk("t4.val0", lsu_val, 32'hA);
    wait_req("t4.req1");
    chk("t4.addr1", mem_addr, 32'h600);
    mem_ack = 1; mem_read_val = 32'hB; step(); idle_in();
    chk("t4.tag1", 32'(lsu_tag), 2);
    chk("t4.empty", lsq_empty, 1);

    // random run against a queue-level model
    rst_n = 0; step(); rst_n = 1;
    mq.delete(); mmode = 0; mreq = 0; mwe = 0; maddr = 0; mdata = 0; mdone = 0; mtag = 0; mval = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = (cyc == 1500 || cyc == 1501) ? 1'b0 : 1'b1;
      issue_en = ($urandom % 3 == 0); issue_store = $urandom % 2; issue_rob_tag = 5'($urandom);
      issue_addr_rdy = $urandom % 2; issue_addr_tag = rnd_tag(); issue_addr_val = $urandom;
      issue_data_rdy = $urandom % 2; issue_data_tag = rnd_tag(); issue_data_val = $urandom;
      cdb_valid = $urandom % 2; cdb_tag = rnd_tag(); cdb_data = $urandom;
      flush = ($urandom % 50 == 0); mem_ack = $urandom % 2; mem_read_val = $urandom;

      mfull = (mq.size() == DEPTH) || (mmode == 2);
      alloc = issue_en && !mfull && !flush;
      ne.st = issue_store; ne.rt = issue_rob_tag;
      ne.ar = issue_addr_rdy || hit(cdb_valid, cdb_tag, issue_addr_tag); ne.at = issue_addr_tag;
      ne.av = issue_addr_rdy ? issue_addr_val : cdb_data;
      ne.dr = issue_data_rdy || hit(cdb_valid, cdb_tag, issue_data_tag); ne.dt = issue_data_tag;
      ne.dv = issue_data_rdy ? issue_data_val : cdb_data;
      elig = (mq.size() > 0) && mq[0].ar && (!mq[0].st || mq[0].dr);
      mdone = 0;
      if (!rst_n) begin
        mq.delete(); mmode = 0; mreq = 0; mwe = 0; maddr = 0; mdata = 0; mtag = 0; mval = 0;
      end else begin
        if (mmode == 0) begin
          if (flush) mq.delete();
          else if (elig) begin
            mreq = 1; mwe = mq[0].st; maddr = mq[0].av; mdata = mq[0].st ? mq[0].dv : 0; mmode = 1;
          end
        end else if (mmode == 1) begin
          if (mem_ack) begin
            mreq = 0; mmode = 0;
            if (flush) mq.delete();
            else begin
              mdone = 1; mtag = mq[0].rt; mval = mq[0].st ? 0 : mem_read_val;
              void'(mq.pop_front());
            end
          end else if (flush) begin
            mq.delete(); mmode = 2;
          end
        end else begin
          if (mem_ack) begin mreq = 0; mmode = 0; end
          if (flush) mq.delete();
        end
        foreach (mq[k]) begin
          if (!mq[k].ar && hit(cdb_valid, cdb_tag, mq[k].at)) begin mq[k].ar = 1; mq[k].av = cdb_data; end
          if (!mq[k].dr && hit(cdb_valid, cdb_tag, mq[k].dt)) begin mq[k].dr = 1; mq[k].dv = cdb_data; end
        end
        if (alloc) mq.push_back(ne);
      end

      step();
      chk($sformatf("r%0d.req", cyc), mem_req, mreq);
      if (mreq) begin
        chk($sformatf("r%0d.we", cyc), mem_we, mwe);
        chk($sformatf("r%0d.addr", cyc), mem_addr, maddr);
        chk($sformatf("r%0d.data", cyc), mem_data, mdata);
      end
      chk($sformatf("r%0d.done", cyc), lsu_done, mdone);
      if (mdone) begin
        chk($sformatf("r%0d.tag", cyc), 32'(lsu_tag), 32'(mtag));
        chk($sformatf("r%0d.val", cyc), lsu_val, mval);
      end
      chk($sformatf("r%0d.full", cyc), lsq_full, (mq.size() == DEPTH) || (mmode == 2));
      chk($sformatf("r%0d.empty", cyc), lsq_empty, mq.size() == 0);
    end
    rst_n = 1;
    idle_in();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
